// File: rtl/mem_burst_pkg.sv
// Shared types and default sizes for the burst master that drives the
// 8 x 8-bit single-port register-file memory.
package mem_burst_pkg;

  localparam int DW_DEF    = 8;
  localparam int AW_DEF    = 4;
  localparam int DEPTH_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    WRITE,
    READ,
    DONE
  } state_t;

  typedef struct packed {
    logic              wr;
    logic [AW_DEF-1:0] addr;
    logic [AW_DEF-1:0] len;
  } cmd_t;

endpackage

// File: rtl/mem_burst_rd_slice.sv
// Single-entry read output register: captures a memory word, holds it
// under backpressure and drains it on rd_ready.
module mem_burst_rd_slice
  import mem_burst_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          capture,
  input  logic [DW-1:0] data_in,
  input  logic          rd_ready,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data
);

  // NOTE: non-blocking assignments keep every register updating from
  // pre-edge values, so capture and drain in one cycle cannot race.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (capture) begin
      rd_valid <= 1'b1;
      rd_data  <= data_in;
    end else if (rd_ready) begin
      rd_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_burst_master.sv
// Burst initiator for the register-file memory. rst_n is a synchronous,
// active-high reset. Define MEM_BURST_WRAP_EN to let bursts wrap at DEPTH.
module mem_burst_master
  import mem_burst_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_wr,
  input  logic [AW-1:0] cmd_addr,
  input  logic [AW-1:0] cmd_len,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          mem_wen,
  output logic          mem_ren,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  state_t        state;
  cmd_t          cmd_q;
  logic [AW-1:0] cur_addr;
  logic [AW-1:0] next_addr;
  logic [AW-1:0] beats_left;
  logic          reject;
  logic          wr_phase;
  logic          rd_phase;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the ifdef branches can infer a latch.
    reject    = ({1'b0, cmd_q.addr} >= DEPTH_W);
    next_addr = cur_addr + 1'b1;
`ifdef MEM_BURST_WRAP_EN
    if (cur_addr == AW'(DEPTH - 1)) next_addr = '0;
`else
    if (({1'b0, cmd_q.addr} + {1'b0, cmd_q.len}) >= DEPTH_W) reject = 1'b1;
`endif
  end

  // Strobes are gated by reset so nothing reaches the memory in the reset cycle.
  assign wr_phase  = (state == WRITE) && !rst_n;
  assign rd_phase  = (state == READ) && !rst_n;
  assign wr_ready  = wr_phase;
  assign mem_wen   = wr_phase && wr_valid;
  assign mem_ren   = rd_phase && (!rd_valid || rd_ready);
  assign mem_addr  = (wr_phase || rd_phase) ? cur_addr : '0;
  assign mem_wdata = wr_phase ? wr_data : '0;
  assign cmd_ready = (state == IDLE) && !rd_valid && !rst_n;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state      <= IDLE;
      cmd_q      <= '0;
      cur_addr   <= '0;
      beats_left <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_q      <= '{wr: cmd_wr, addr: cmd_addr, len: cmd_len};
            cur_addr   <= cmd_addr;
            beats_left <= cmd_len;
            state      <= CHECK;
          end
        end
        CHECK: begin
          if (reject) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            state <= cmd_q.wr ? WRITE : READ;
          end
        end
        WRITE, READ: begin
          if (mem_wen || mem_ren) begin
            cur_addr   <= next_addr;
            beats_left <= beats_left - 1'b1;
            if (beats_left == '0) begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  mem_burst_rd_slice #(.DW(DW)) u_rd_slice (
    .clk      (clk),
    .rst_n    (rst_n),
    .capture  (mem_ren),
    .data_in  (mem_rdata),
    .rd_ready (rd_ready),
    .rd_valid (rd_valid),
    .rd_data  (rd_data)
  );

endmodule

// File: tb/tb_mem_burst_master.sv
// Directed bench for mem_burst_master with an 8 x 8-bit memory model.
module tb_mem_burst_master;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_wr;
  logic [3:0] cmd_addr, cmd_len;
  logic       wr_valid, wr_ready;
  logic [7:0] wr_data;
  logic       rd_valid, rd_ready;
  logic [7:0] rd_data;
  logic       busy, done, err;
  logic       mem_wen, mem_ren;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata;

  logic [7:0] mem [16];
  logic [7:0] golden [8];
  int wen_cnt = 0, ren_cnt = 0, done_cnt = 0, both_cnt = 0;
  int compared = 0, mismatched = 0;

  mem_burst_master dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .busy(busy), .done(done), .err(err),
    .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_wen) begin
      mem[mem_addr] <= mem_wdata;
      wen_cnt <= wen_cnt + 1;
    end
    if (mem_ren) ren_cnt <= ren_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (mem_wen && mem_ren) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offers a command and returns at the negedge of the CHECK cycle.
  task automatic do_cmd(input logic wr, input logic [3:0] addr, input logic [3:0] len);
    int w = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_len = len;
    #1;
    while (!cmd_ready && w < 20) begin
      @(negedge clk); #1; w++;
    end
    check("cmd_accept", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic write_burst(input logic [3:0] addr, input logic [3:0] len,
                             input logic [7:0] base, input int stall_at, input int stall_len);
    int wen0, ea;
    do_cmd(1'b1, addr, len);
    wen0 = wen_cnt;
    wr_valid = 1'b0; #1;
    check("wr_check_wen", mem_wen, 0);
    check("wr_check_busy", busy, 1);
    for (int b = 0; b <= int'(len); b++) begin
      if (b == stall_at) begin
        repeat (stall_len) begin
          @(negedge clk); wr_valid = 1'b0; #1;
          check("stall_wen", mem_wen, 0);
          check("stall_busy", busy, 1);
        end
      end
      @(negedge clk);
      wr_valid = 1'b1; wr_data = base + 8'(b); #1;
      ea = (int'(addr) + b) % 8;
      check("wr_wen", mem_wen, 1);
      check("wr_addr", mem_addr, ea);
      check("wr_wdata", mem_wdata, base + 8'(b));
      golden[ea] = base + 8'(b);
    end
    @(negedge clk); wr_valid = 1'b0; #1;
    check("wr_done", done, 1);
    check("wr_done_wen", mem_wen, 0);
    @(negedge clk); #1;
    check("wr_done_pulse", done, 0);
    check("wr_idle_busy", busy, 0);
    check("wr_idle_ready", cmd_ready, 1);
    check("wr_count", wen_cnt - wen0, int'(len) + 1);
  endtask

  task automatic read_burst(input logic [3:0] addr, input logic [3:0] len, input bit toggle);
    int got = 0, cyc = 0, ren0, done0;
    logic prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    do_cmd(1'b0, addr, len);
    ren0 = ren_cnt; done0 = done_cnt;
    while (got <= int'(len) && cyc < 80) begin
      rd_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      #1;
      if (rd_valid && !rd_ready) check("rd_stall_ren", mem_ren, 0);
      if (prev_stall) check("rd_hold", rd_data, prev_data);
      if (rd_valid && rd_ready) begin
        check("rd_beat", rd_data, golden[(int'(addr) + got) % 8]);
        got++;
      end
      prev_stall = rd_valid && !rd_ready;
      prev_data  = rd_data;
      @(negedge clk); cyc++;
    end
    rd_ready = 1'b0; #1;
    check("rd_got", got, int'(len) + 1);
    check("rd_ren_count", ren_cnt - ren0, int'(len) + 1);
    check("rd_done_count", done_cnt - done0, 1);
    check("rd_idle_busy", busy, 0);
    check("rd_drained", rd_valid, 0);
    check("rd_idle_ready", cmd_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int wen0, ren0, done0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    for (int i = 0; i < 8; i++) golden[i] = 8'h00;
    rst_n = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_wen", mem_wen, 0);
    check("rst_ren", mem_ren, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_wr_ready", wr_ready, 0);
    @(negedge clk); rst_n = 1'b0; #1;
    check("rel_cmd_ready", cmd_ready, 1);

    // Write burst addr 2, 4 beats, then read back
    write_burst(4'd2, 4'd3, 8'hA1, -1, 0);
    read_burst(4'd2, 4'd3, 1'b0);

    // Full-memory write with a 5-cycle stall, then read with backpressure
    write_burst(4'd0, 4'd7, 8'h30, 3, 5);
    read_burst(4'd0, 4'd7, 1'b1);

    // Illegal start address
    wen0 = wen_cnt; ren0 = ren_cnt;
    do_cmd(1'b1, 4'd9, 4'd0);
    #1;
    check("ill_check_err", err, 0);
    check("ill_check_busy", busy, 1);
    @(negedge clk); #1;
    check("ill_err", err, 1);
    check("ill_busy", busy, 0);
    check("ill_ready", cmd_ready, 1);
    @(negedge clk); #1;
    check("ill_err_pulse", err, 0);
    check("ill_wen_count", wen_cnt - wen0, 0);
    check("ill_ren_count", ren_cnt - ren0, 0);

    // Burst crossing the end of memory
`ifdef MEM_BURST_WRAP_EN
    write_burst(4'd6, 4'd3, 8'h11, -1, 0);
`else
    wen0 = wen_cnt;
    do_cmd(1'b1, 4'd6, 4'd3);
    wr_valid = 1'b1; wr_data = 8'h11; #1;
    check("cross_check_wen", mem_wen, 0);
    @(negedge clk); #1;
    check("cross_err", err, 1);
    check("cross_wen", mem_wen, 0);
    check("cross_ready", cmd_ready, 1);
    wr_valid = 1'b0;
    @(negedge clk); #1;
    check("cross_err_pulse", err, 0);
    check("cross_wen_count", wen_cnt - wen0, 0);
`endif

    // Reset after 2 of 4 write beats
    done0 = done_cnt;
    do_cmd(1'b1, 4'd2, 4'd3);
    wen0 = wen_cnt;
    wr_valid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk); wr_valid = 1'b1; wr_data = 8'h51 + 8'(b); #1;
      check("mid_wen", mem_wen, 1);
      golden[2 + b] = 8'h51 + 8'(b);
    end
    @(negedge clk); rst_n = 1'b1; wr_data = 8'h53; #1;
    check("mid_rst_wen", mem_wen, 0);
    check("mid_rst_ready", cmd_ready, 0);
    @(negedge clk); rst_n = 1'b0; #1;
    check("mid_busy", busy, 0);
    check("mid_ready", cmd_ready, 1);
    check("mid_post_wen", mem_wen, 0);
    repeat (2) @(negedge clk);
    #1;
    check("mid_post_wen2", mem_wen, 0);
    wr_valid = 1'b0;
    check("mid_wen_count", wen_cnt - wen0, 2);
    check("mid_no_done", done_cnt - done0, 0);
    check("mid_mem4", mem[4], golden[4]);

    // Final read-back of the whole memory
    read_burst(4'd0, 4'd7, 1'b0);
    check("no_dual_strobe", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_burst_master.md
Name: mem_burst_master

Overview:
- Initiator for the team's small single-port register-file memory (8 x 8-bit, write on posedge, combinational read).
- Accepts burst commands (write/read, start address, beat count) over valid/ready.
- Streams write data in and read data out, with backpressure.
- Drives the memory's wen/ren/addr/wdata pins and samples its read data.

Parameters:
- DW, 8, data width; matches memory wdata/data_out.
- AW, 4, address width; matches memory addr.
- DEPTH, 8, number of implemented words; legal addresses are 0..DEPTH-1.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  reset, synchronous, active-high: rst_n=1 at a posedge resets the block.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready.
- cmd_wr  in  1  1=write burst, 0=read burst.
- cmd_addr  in  AW  start address.
- cmd_len  in  AW  beats minus 1 (0 => 1 beat).
- wr_valid  in  1  write beat offered.
- wr_ready  out  1  write beat consumed.
- wr_data  in  DW  write beat data.
- rd_valid  out  1  read beat available.
- rd_ready  in  1  consumer accepts read beat.
- rd_data  out  DW  read beat data.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse, burst complete.
- err  out  1  one-cycle pulse, command rejected.
- mem_wen  out  1  memory write strobe.
- mem_ren  out  1  memory read enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory combinational read data.

Behaviour:
- Reset values: state=IDLE, cmd_ready=0 during the reset cycle; rd_valid=0, rd_data=0, done=0, err=0, busy=0; all mem_* outputs 0.
- Reset mid-burst: abort at the next posedge. No memory strobes in or after the reset cycle. Remaining beats are dropped and no done is issued.
- FSM states: IDLE, CHECK, WRITE, READ, DONE.
- IDLE:
  - cmd_ready = !rd_valid.
  - On accept, latch op, cur_addr=cmd_addr, beats_left=cmd_len, then go to CHECK.
- CHECK (1 cycle):
  - Reject if cmd_addr >= DEPTH, or (no wrap, see option) if cmd_addr+cmd_len >= DEPTH. Compute the sum in AW+1 bits.
  - On reject: err=1 next cycle, return to IDLE, no memory access.
  - Otherwise go to WRITE or READ.
- WRITE:
  - wr_ready=1 combinationally.
  - mem_wen=wr_valid, mem_addr=cur_addr, mem_wdata=wr_data, all combinational. One beat per cycle at most.
  - Each beat: cur_addr++, beats_left--.
  - After the beat with beats_left==0, go to DONE.
  - wr_valid low stalls; no timeout.
- READ:
  - mem_ren = !rd_valid || rd_ready; mem_addr=cur_addr.
  - When mem_ren=1, rd_data<=mem_rdata and rd_valid<=1 at the posedge; advance cur_addr/beats_left.
  - rd_valid clears when rd_ready&&rd_valid with no new capture.
  - Throughput is 1 beat/cycle with rd_ready held high. rd_data is held stable while rd_valid&&!rd_ready.
  - After the last mem_ren, go to DONE.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - The final read beat may still be pending. cmd_ready stays 0 until it is drained.
- Latency: command accepted at cycle N; first memory access at N+2 (CHECK in N+1).
- mem_ren and mem_wen are never both 1. Strobes are 0 outside WRITE/READ.
- cmd_len=0 gives a single-beat burst.

Optional Feature:
- Macro: MEM_BURST_WRAP_EN.
- Defined: addresses wrap from DEPTH-1 to 0 within a burst. Only cmd_addr >= DEPTH is rejected. Bursts longer than DEPTH revisit addresses.
- Undefined: any burst crossing DEPTH-1 is rejected with err; cur_addr never wraps.

Decomposition:
- Shared package mem_burst_pkg holds:
  - state enum (IDLE, CHECK, WRITE, READ, DONE);
  - DW/AW/DEPTH default constants;
  - command struct {wr, addr, len}.
- One natural sub-module: mem_burst_rd_slice, the single-entry read output register (capture/hold/drain logic with rd_valid/rd_ready).

Test Plan:
- Write burst: cmd_wr=1, addr=2, len=3, wr_data 0xA1,0xA2,0xA3,0xA4 back-to-back. Expect mem_wen on 4 consecutive cycles at addr 2,3,4,5, then one-cycle done. Read-back burst returns A1..A4.
- Read with backpressure: read addr=0, len=7, rd_ready toggling 1/0. Expect all 8 words in order, no drop or duplicate, rd_data stable during stalls, mem_ren=0 while stalled and full.
- Illegal start: cmd_addr=9. Expect err pulse 2 cycles after accept, zero mem strobes, cmd_ready back to 1.
- Crossing end: addr=6, len=3, write 0x11..0x14. Without macro: err, no writes. With MEM_BURST_WRAP_EN: writes to 6,7,0,1.
- Reset mid-write: assert rst_n=1 after 2 of 4 beats. Expect only addresses 2,3 written, no further mem_wen, no done, state IDLE, cmd_ready=1 after release.
- Write stall: wr_valid low for 5 cycles mid-burst. Expect no mem_wen during the gap, busy=1, burst completes correctly.
